issue_rat_freelist_arbiter: RTL and testbench
=============================================

# issue_rat_freelist_arbiter

Front-end controller for `issue_rat_freelist`. It shares the single freelist acquire port between two rename lanes with round-robin arbitration. It merges two PRF-release sources (retire release and rollback release) into the single freelist redeem port through a small FIFO. It forwards FGR commit/abandon to the freelist and suppresses acquisition while an abandon is in flight. It sits between the rename stage and `issue_rat_freelist`.

## Interface
- `RDQ_DEPTH`, 4: redeem FIFO entries; power of two, ≥2.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `i_acq0_valid` / `i_acq1_valid` in 1: lane 0/1 requests one PRF.
- `i_acq0_fgr` / `i_acq1_fgr` in 4: FGR tag of the request.
- `i_acq0_spec` / `i_acq1_spec` in 1: request is speculative.
- `o_acq0_grant` / `o_acq1_grant` out 1: request accepted this cycle.
- `o_acq_prf` out 6: allocated PRF; valid for whichever grant is high.
- `i_rel0_prf` / `i_rel1_prf` in 6: release PRF; 0 = retire path, 1 = rollback path.
- `i_rel0_valid` / `i_rel1_valid` in 1: release request.
- `o_rel0_ready` / `o_rel1_ready` out 1: release accepted when valid&ready.
- `i_commit_fgr` in 4, `i_commit_valid` in 1: FGR commit from the ROB.
- `i_abandon_fgr` in 4, `i_abandon_valid` in 1: FGR abandon from the ROB.
- `o_fl_redeemed_prf` out 6, `o_fl_redeemed_valid` out 1, `i_fl_redeemed_ready` in 1: freelist redeem port.
- `i_fl_acquire_prf` in 6, `i_fl_acquire_ready` in 1: freelist acquire outputs.
- `o_fl_acquire_fgr` out 4, `o_fl_acquire_fgr_speculative` out 1, `o_fl_acquire_valid` out 1: freelist acquire inputs.
- `o_fl_commit_fgr` out 4, `o_fl_commit_valid` out 1, `o_fl_abandon_fgr` out 4, `o_fl_abandon_valid` out 1: freelist commit/abandon inputs.
- `o_rdq_count` out clog2(RDQ_DEPTH+1): redeem FIFO occupancy.

## Operation
- **Acquire arbitration** (combinational grant, registered pointer `rr_ptr`, 0 = lane 0 preferred):
  - Eligibility: `elig = i_fl_acquire_ready & ~i_abandon_valid`.
  - Both lanes valid and eligible: grant lane `rr_ptr`.
  - Exactly one lane valid and eligible: grant that lane.
  - At most one grant per cycle.
- **Acquire forwarding:**
  - `o_fl_acquire_valid` = OR of grants.
  - `o_fl_acquire_fgr` and `o_fl_acquire_fgr_speculative` are muxed from the granted lane; lane 0 fields when there is no grant.
  - `o_acq_prf = i_fl_acquire_prf`.
- **rr_ptr update:** on any grant, `rr_ptr <= ~granted_lane_index`. Otherwise it holds.
- **Redeem FIFO:** `RDQ_DEPTH` × 6-bit circular buffer, with head/tail pointers of clog2(RDQ_DEPTH) bits that wrap modulo depth, and a count register.
  - `o_rel1_ready = count < RDQ_DEPTH`.
  - `o_rel0_ready = (count + (i_rel1_valid ? 1 : 0)) < RDQ_DEPTH`. Rollback has priority for the last free slot.
  - Both sources may push in the same cycle. Rollback is written at `tail`, retire at `tail+1`; tail advances by the number of pushes.
  - Readiness uses the registered count only; a same-cycle pop does not free space.
  - Pop: `o_fl_redeemed_valid = count != 0`, `o_fl_redeemed_prf = mem[head]`. On valid&`i_fl_redeemed_ready`, head advances by 1.
  - `count <= count + pushes - pop`, always in range 0..RDQ_DEPTH.
- **Commit/abandon:** combinational pass-through to the freelist ports.

## Timing
- Acquire: zero-latency. The grant and PRF appear in the same cycle as the request.
- Release to `o_fl_redeemed_valid`: 1 cycle minimum. There is no bypass; an empty FIFO accepts the push and presents it on the next cycle.
- Throughput:
  - 1 acquire/cycle.
  - Up to 2 pushes/cycle into the FIFO.
  - 1 redeem/cycle out of the FIFO.
- **Reset** (synchronous): `rr_ptr=0`, head=tail=0, count=0. Consequences:
  - `o_fl_redeemed_valid=0` and `o_rdq_count=0`.
  - Both `o_rel*_ready=1` on the next cycle.
  - No grants are issued while `reset` is high.
  - FIFO contents are discarded when reset is asserted mid-operation.
- Abandon in the same cycle as an acquire request: no grant, and `rr_ptr` is unchanged. The request must be re-presented in a later cycle.
- `i_fl_acquire_ready=0`: no grant, and `rr_ptr` holds.

## Structure
- Shared package `issue_rat_pkg` holds:
  - `PRF_W=6`, `FGR_W=4`.
  - Typedefs `prf_t`, `fgr_t`.
- Sub-module `issue_rat_redeem_fifo`: 2-write/1-read FIFO with count output.
- Arbiter and forwarding logic stay in the top module.

## Test plan
- **Reset:** after reset, `o_rdq_count=0`, `o_fl_redeemed_valid=0`, `o_rel0_ready=o_rel1_ready=1`, and no grants.
- **Round-robin:** both lanes valid for 4 cycles with `i_fl_acquire_ready=1` gives grants 0,1,0,1. Each granted PRF equals `i_fl_acquire_prf` for that cycle, and the forwarded fgr/spec match the granted lane.
- **Abandon blocking:** `i_abandon_valid=1` with lane 1 requesting gives no grant and `o_fl_abandon_valid=1`. On the next cycle, lane 1 is granted and `rr_ptr` has been preserved.
- **Dual push:** with an empty FIFO and `i_fl_redeemed_ready=0`, push rel1=0x21 and rel0=0x05 in one cycle, giving count=2. Then raise ready: the redeem port emits 0x21, then 0x05, then valid drops.
- **Full/priority:** with count=3 and both sources valid, `o_rel1_ready=1` and `o_rel0_ready=0`, so count becomes 4. With count=4, both readies are 0, even while a pop is in progress.
- **Wrap-around:** 10 single pushes with continuous drain produce outputs in order and count never exceeds 1.

Source files
------------

// File: rtl/issue_rat_pkg.sv
// Shared widths and types for the rename/freelist front end.
package issue_rat_pkg;

  localparam int PRF_W = 6;
  localparam int FGR_W = 4;

  typedef logic [PRF_W-1:0] prf_t;
  typedef logic [FGR_W-1:0] fgr_t;

  // Lane index used by the acquire arbiter.
  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

// File: rtl/issue_rat_redeem_fifo.sv
// Two-write / one-read circular FIFO that merges the rollback and retire
// release streams into the single freelist redeem port.
// Write port "rb" (rollback) owns the last free slot; port "rt" (retire)
// lands behind it when both push in the same cycle.
module issue_rat_redeem_fifo
  import issue_rat_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_rb_valid,
  input  prf_t          i_rb_prf,
  output logic          o_rb_ready,
  input  logic          i_rt_valid,
  input  prf_t          i_rt_prf,
  output logic          o_rt_ready,
  output logic          o_pop_valid,
  output prf_t          o_pop_prf,
  input  logic          i_pop_ready,
  output logic [CW-1:0] o_count
);

  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  prf_t          mem [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  logic [CW:0]   count_ext;
  logic          rb_push;
  logic          rt_push;
  logic          pop;
  logic [PW-1:0] rt_addr;

  // Readiness looks only at the registered count: a pop in the same cycle
  // never makes room for a push, which keeps ready off the pop_ready path.
  assign count_ext  = {1'b0, count_reg};
  assign o_rb_ready = count_ext < DEPTH_C;
  assign o_rt_ready = (count_ext + {{CW{1'b0}}, i_rb_valid}) < DEPTH_C;

  assign rb_push = i_rb_valid & o_rb_ready;
  assign rt_push = i_rt_valid & o_rt_ready;
  assign pop     = o_pop_valid & i_pop_ready;

  // Retire goes one slot behind rollback only when rollback also pushes.
  assign rt_addr = tail_reg + PW'(rb_push);

  assign o_pop_valid = (count_reg != '0);
  assign o_pop_prf   = mem[head_reg];
  assign o_count     = count_reg;

  // Storage writes; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (rb_push) mem[tail_reg] <= i_rb_prf;
    if (rt_push) mem[rt_addr]  <= i_rt_prf;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      tail_reg  <= tail_reg + PW'(rb_push) + PW'(rt_push);
      head_reg  <= head_reg + PW'(pop);
      count_reg <= count_reg + CW'(rb_push) + CW'(rt_push) - CW'(pop);
    end
  end

endmodule

// File: rtl/issue_rat_freelist_arbiter.sv
// Front-end controller for the freelist: round-robin sharing of the acquire
// port between two rename lanes, release merging through the redeem FIFO,
// and pass-through of FGR commit/abandon.
module issue_rat_freelist_arbiter
  import issue_rat_pkg::*;
#(
  parameter int RDQ_DEPTH = 4,
  localparam int CW = $clog2(RDQ_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  // rename lanes
  input  logic          i_acq0_valid,
  input  fgr_t          i_acq0_fgr,
  input  logic          i_acq0_spec,
  input  logic          i_acq1_valid,
  input  fgr_t          i_acq1_fgr,
  input  logic          i_acq1_spec,
  output logic          o_acq0_grant,
  output logic          o_acq1_grant,
  output prf_t          o_acq_prf,
  // release sources: 0 = retire, 1 = rollback
  input  prf_t          i_rel0_prf,
  input  logic          i_rel0_valid,
  output logic          o_rel0_ready,
  input  prf_t          i_rel1_prf,
  input  logic          i_rel1_valid,
  output logic          o_rel1_ready,
  // ROB commit / abandon
  input  fgr_t          i_commit_fgr,
  input  logic          i_commit_valid,
  input  fgr_t          i_abandon_fgr,
  input  logic          i_abandon_valid,
  // freelist redeem port
  output prf_t          o_fl_redeemed_prf,
  output logic          o_fl_redeemed_valid,
  input  logic          i_fl_redeemed_ready,
  // freelist acquire port
  input  prf_t          i_fl_acquire_prf,
  input  logic          i_fl_acquire_ready,
  output fgr_t          o_fl_acquire_fgr,
  output logic          o_fl_acquire_fgr_speculative,
  output logic          o_fl_acquire_valid,
  // freelist commit / abandon
  output fgr_t          o_fl_commit_fgr,
  output logic          o_fl_commit_valid,
  output fgr_t          o_fl_abandon_fgr,
  output logic          o_fl_abandon_valid,
  // redeem FIFO occupancy
  output logic [CW-1:0] o_rdq_count
);

  lane_e rr_ptr_reg;
  logic  elig;
  logic  req0;
  logic  req1;
  logic  grant0;
  logic  grant1;

  // An in-flight abandon may be reclaiming the very PRFs a lane would get,
  // so acquisition is held off that cycle; reset also blocks grants.
  assign elig = i_fl_acquire_ready & ~i_abandon_valid & ~reset;
  assign req0 = i_acq0_valid & elig;
  assign req1 = i_acq1_valid & elig;

  // Grant selection: lone requester wins, contention resolved by rr_ptr.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0 && req1) begin
      grant0 = (rr_ptr_reg == LANE0);
      grant1 = (rr_ptr_reg == LANE1);
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
  end

  assign o_acq0_grant = grant0;
  assign o_acq1_grant = grant1;
  assign o_acq_prf    = i_fl_acquire_prf;

  // Forward the granted lane's tag; lane 0 fields are the idle default.
  always_comb begin
    o_fl_acquire_valid           = grant0 | grant1;
    o_fl_acquire_fgr             = i_acq0_fgr;
    o_fl_acquire_fgr_speculative = i_acq0_spec;
    if (grant1) begin
      o_fl_acquire_fgr             = i_acq1_fgr;
      o_fl_acquire_fgr_speculative = i_acq1_spec;
    end
  end

  // Round-robin pointer: after a grant, the other lane is preferred next.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= LANE0;
    end else if (grant0) begin
      rr_ptr_reg <= LANE1;
    end else if (grant1) begin
      rr_ptr_reg <= LANE0;
    end
  end

  assign o_fl_commit_fgr    = i_commit_fgr;
  assign o_fl_commit_valid  = i_commit_valid;
  assign o_fl_abandon_fgr   = i_abandon_fgr;
  assign o_fl_abandon_valid = i_abandon_valid;

  // Rollback (rel1) takes the priority write port of the FIFO.
  issue_rat_redeem_fifo #(
    .DEPTH(RDQ_DEPTH)
  ) u_rdq (
    .clk        (clk),
    .reset      (reset),
    .i_rb_valid (i_rel1_valid),
    .i_rb_prf   (i_rel1_prf),
    .o_rb_ready (o_rel1_ready),
    .i_rt_valid (i_rel0_valid),
    .i_rt_prf   (i_rel0_prf),
    .o_rt_ready (o_rel0_ready),
    .o_pop_valid(o_fl_redeemed_valid),
    .o_pop_prf  (o_fl_redeemed_prf),
    .i_pop_ready(i_fl_redeemed_ready),
    .o_count    (o_rdq_count)
  );

endmodule

// File: tb/tb_issue_rat_freelist_arbiter.sv
// Bench for issue_rat_freelist_arbiter: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_issue_rat_freelist_arbiter;

  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic reset;
  logic i_acq0_valid, i_acq1_valid, i_acq0_spec, i_acq1_spec;
  logic [3:0] i_acq0_fgr, i_acq1_fgr;
  logic o_acq0_grant, o_acq1_grant;
  logic [5:0] o_acq_prf;
  logic [5:0] i_rel0_prf, i_rel1_prf;
  logic i_rel0_valid, i_rel1_valid, o_rel0_ready, o_rel1_ready;
  logic [3:0] i_commit_fgr, i_abandon_fgr;
  logic i_commit_valid, i_abandon_valid;
  logic [5:0] o_fl_redeemed_prf;
  logic o_fl_redeemed_valid, i_fl_redeemed_ready;
  logic [5:0] i_fl_acquire_prf;
  logic i_fl_acquire_ready;
  logic [3:0] o_fl_acquire_fgr;
  logic o_fl_acquire_fgr_speculative, o_fl_acquire_valid;
  logic [3:0] o_fl_commit_fgr, o_fl_abandon_fgr;
  logic o_fl_commit_valid, o_fl_abandon_valid;
  logic [CW-1:0] o_rdq_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  issue_rat_freelist_arbiter #(.RDQ_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .i_acq0_valid(i_acq0_valid), .i_acq0_fgr(i_acq0_fgr), .i_acq0_spec(i_acq0_spec),
    .i_acq1_valid(i_acq1_valid), .i_acq1_fgr(i_acq1_fgr), .i_acq1_spec(i_acq1_spec),
    .o_acq0_grant(o_acq0_grant), .o_acq1_grant(o_acq1_grant), .o_acq_prf(o_acq_prf),
    .i_rel0_prf(i_rel0_prf), .i_rel0_valid(i_rel0_valid), .o_rel0_ready(o_rel0_ready),
    .i_rel1_prf(i_rel1_prf), .i_rel1_valid(i_rel1_valid), .o_rel1_ready(o_rel1_ready),
    .i_commit_fgr(i_commit_fgr), .i_commit_valid(i_commit_valid),
    .i_abandon_fgr(i_abandon_fgr), .i_abandon_valid(i_abandon_valid),
    .o_fl_redeemed_prf(o_fl_redeemed_prf), .o_fl_redeemed_valid(o_fl_redeemed_valid),
    .i_fl_redeemed_ready(i_fl_redeemed_ready),
    .i_fl_acquire_prf(i_fl_acquire_prf), .i_fl_acquire_ready(i_fl_acquire_ready),
    .o_fl_acquire_fgr(o_fl_acquire_fgr),
    .o_fl_acquire_fgr_speculative(o_fl_acquire_fgr_speculative),
    .o_fl_acquire_valid(o_fl_acquire_valid),
    .o_fl_commit_fgr(o_fl_commit_fgr), .o_fl_commit_valid(o_fl_commit_valid),
    .o_fl_abandon_fgr(o_fl_abandon_fgr), .o_fl_abandon_valid(o_fl_abandon_valid),
    .o_rdq_count(o_rdq_count)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pref = 0;       // lane preferred under contention
  int m_q[$];           // FIFO contents, oldest first
  bit model_ok = 0;

  // Per-cycle compare at negedge, model advance at posedge.
  initial begin
    int eg0, eg1, r1, r0, pop;
    bit elig;
    forever begin
      @(negedge clk);
      elig = i_fl_acquire_ready && !i_abandon_valid && !reset;
      eg0 = 0; eg1 = 0;
      if (elig && i_acq0_valid && i_acq1_valid) begin
        if (m_pref == 0) eg0 = 1; else eg1 = 1;
      end else if (elig && i_acq0_valid) eg0 = 1;
      else if (elig && i_acq1_valid) eg1 = 1;
      r1 = (m_q.size() < D) ? 1 : 0;
      r0 = (m_q.size() + (i_rel1_valid ? 1 : 0) < D) ? 1 : 0;
      if (model_ok) begin
        check("m_grant0", int'(o_acq0_grant), eg0);
        check("m_grant1", int'(o_acq1_grant), eg1);
        check("m_acq_valid", int'(o_fl_acquire_valid), eg0 | eg1);
        check("m_acq_prf", int'(o_acq_prf), int'(i_fl_acquire_prf));
        check("m_acq_fgr", int'(o_fl_acquire_fgr), eg1 ? int'(i_acq1_fgr) : int'(i_acq0_fgr));
        check("m_acq_spec", int'(o_fl_acquire_fgr_speculative),
              eg1 ? int'(i_acq1_spec) : int'(i_acq0_spec));
        check("m_rel1_ready", int'(o_rel1_ready), r1);
        check("m_rel0_ready", int'(o_rel0_ready), r0);
        check("m_count", int'(o_rdq_count), m_q.size());
        check("m_rd_valid", int'(o_fl_redeemed_valid), (m_q.size() != 0) ? 1 : 0);
        if (m_q.size() != 0) check("m_rd_prf", int'(o_fl_redeemed_prf), m_q[0]);
        check("m_commit", int'({o_fl_commit_valid, o_fl_commit_fgr}),
              int'({i_commit_valid, i_commit_fgr}));
        check("m_abandon", int'({o_fl_abandon_valid, o_fl_abandon_fgr}),
              int'({i_abandon_valid, i_abandon_fgr}));
      end
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_pref = 0;
        model_ok = 1;
      end else begin
        pop = (m_q.size() != 0 && i_fl_redeemed_ready) ? 1 : 0;
        if (pop != 0) void'(m_q.pop_front());
        if (i_rel1_valid && r1 != 0) m_q.push_back(int'(i_rel1_prf));
        if (i_rel0_valid && r0 != 0) m_q.push_back(int'(i_rel0_prf));
        if (eg0 != 0) m_pref = 1;
        else if (eg1 != 0) m_pref = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {i_acq0_valid, i_acq1_valid, i_acq0_spec, i_acq1_spec} = '0;
    i_acq0_fgr = '0; i_acq1_fgr = '0;
    i_rel0_prf = '0; i_rel1_prf = '0; i_rel0_valid = 0; i_rel1_valid = 0;
    i_commit_fgr = 4'h7; i_commit_valid = 1'b1;
    i_abandon_fgr = '0; i_abandon_valid = 0;
    i_fl_redeemed_ready = 0; i_fl_acquire_prf = 6'h3f; i_fl_acquire_ready = 1'b1;
    i_acq0_valid = 1'b1;                 // request during reset must not be granted
    #2;
    check("rst_no_grant", int'(o_acq0_grant), 0);
    cyc(); cyc();
    reset = 1'b0; i_acq0_valid = 1'b0; i_commit_valid = 1'b0;
    #2;
    check("rst_count", int'(o_rdq_count), 0);
    check("rst_rd_valid", int'(o_fl_redeemed_valid), 0);
    check("rst_rdy", int'({o_rel0_ready, o_rel1_ready}), 3);

    // Round-robin with both lanes requesting
    i_acq0_valid = 1; i_acq0_fgr = 4'h3; i_acq0_spec = 1;
    i_acq1_valid = 1; i_acq1_fgr = 4'ha; i_acq1_spec = 0;
    for (int k = 0; k < 4; k++) begin
      i_fl_acquire_prf = 6'(10 + k);
      #2;
      check("rr_grants", int'({o_acq1_grant, o_acq0_grant}), (k % 2 == 0) ? 1 : 2);
      check("rr_prf", int'(o_acq_prf), 10 + k);
      check("rr_fgr", int'({o_fl_acquire_fgr_speculative, o_fl_acquire_fgr}),
            (k % 2 == 0) ? 'h13 : 'h0a);
      cyc();
    end

    // Freelist not ready: no grant
    i_fl_acquire_ready = 0;
    #2;
    check("flrdy_block", int'({o_acq1_grant, o_acq0_grant}), 0);
    cyc();
    i_fl_acquire_ready = 1;

    // Abandon blocking with lane 1 alone
    i_acq0_valid = 0; i_abandon_valid = 1; i_abandon_fgr = 4'h5;
    #2;
    check("abn_grant", int'({o_acq1_grant, o_acq0_grant}), 0);
    check("abn_fwd", int'({o_fl_abandon_valid, o_fl_abandon_fgr}), 'h15);
    cyc();
    i_abandon_valid = 0;
    #2;
    check("abn_retry", int'({o_acq1_grant, o_acq0_grant}), 2);
    cyc();
    i_acq0_valid = 1;                    // lane 1 just won, lane 0 preferred
    #2;
    check("abn_rr", int'({o_acq1_grant, o_acq0_grant}), 1);
    cyc();
    i_acq0_valid = 0; i_acq1_valid = 0;

    // Dual push, then drain in order
    i_rel1_valid = 1; i_rel1_prf = 6'h21; i_rel0_valid = 1; i_rel0_prf = 6'h05;
    cyc();
    i_rel1_valid = 0; i_rel0_valid = 0;
    #2;
    check("dual_count", int'(o_rdq_count), 2);
    check("dual_first", int'(o_fl_redeemed_prf), 'h21);
    i_fl_redeemed_ready = 1;
    cyc(); #2;
    check("dual_second", int'({o_fl_redeemed_valid, o_fl_redeemed_prf}), 'h45);
    cyc(); #2;
    check("dual_empty", int'(o_fl_redeemed_valid), 0);
    i_fl_redeemed_ready = 0;

    // Fill to 3, then rollback priority on the last slot
    i_rel1_valid = 1; i_rel1_prf = 6'h11; i_rel0_valid = 1; i_rel0_prf = 6'h12;
    cyc();
    i_rel0_valid = 0; i_rel1_prf = 6'h13;
    cyc();
    i_rel0_valid = 1; i_rel1_prf = 6'h14; i_rel0_prf = 6'h15;
    #2;
    check("full3_count", int'(o_rdq_count), 3);
    check("full3_rdy", int'({o_rel1_ready, o_rel0_ready}), 2);
    cyc();
    i_fl_redeemed_ready = 1;
    #2;
    check("full4_count", int'(o_rdq_count), 4);
    check("full4_rdy", int'({o_rel1_ready, o_rel0_ready}), 0);
    cyc();
    i_rel0_valid = 0; i_rel1_valid = 0;
    #2;
    check("full_pop", int'(o_rdq_count), 3);
    check("full_order", int'(o_fl_redeemed_prf), 'h12);
    for (int k = 0; k < 3; k++) cyc();
    #2;
    check("full_drained", int'(o_rdq_count), 0);

    // Wrap-around: single pushes with continuous drain
    for (int k = 0; k < 10; k++) begin
      i_rel0_valid = 1; i_rel0_prf = 6'(8'h30 + k);
      cyc(); #2;
      check("wrap_count", int'(o_rdq_count), 1);
      check("wrap_prf", int'(o_fl_redeemed_prf), 'h30 + k);
    end
    i_rel0_valid = 0;
    cyc(); #2;
    check("wrap_empty", int'(o_rdq_count), 0);

    // Mid-operation reset discards contents
    i_fl_redeemed_ready = 0;
    i_rel1_valid = 1; i_rel1_prf = 6'h2a; i_rel0_valid = 1; i_rel0_prf = 6'h2b;
    cyc();
    i_rel1_valid = 0; i_rel0_valid = 0;
    reset = 1;
    cyc();
    reset = 0;
    #2;
    check("mid_rst_count", int'(o_rdq_count), 0);
    check("mid_rst_valid", int'(o_fl_redeemed_valid), 0);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
